// File: rtl/sik_mem_arbiter_if.sv
// Thread request/ack channels plus the shared data-memory port of the SIK arbiter.
// slave: the arbiter side; master: the threads and memory driving it.
interface sik_mem_arbiter_if #(
    parameter int AW = 16
);
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [15:0]   wdata1;
    logic          ack1;
    logic [15:0]   rdata1;

    logic          req2;
    logic          we2;
    logic [AW-1:0] addr2;
    logic [15:0]   wdata2;
    logic          ack2;
    logic [15:0]   rdata2;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          busy;

    modport slave (
        input  req1, we1, addr1, wdata1,
        input  req2, we2, addr2, wdata2,
        input  mem_rdata,
        output ack1, rdata1, ack2, rdata2,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req1, we1, addr1, wdata1,
        output req2, we2, addr2, wdata2,
        output mem_rdata,
        input  ack1, rdata1, ack2, rdata2,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/sik_mem_arbiter.sv
// Round-robin arbiter for the two SIK threads onto one fixed-latency memory port; one access at a time.
// Latency 2+MEM_LAT cycles from req sample to ack; requesters are held off simply by withholding ack.
module sik_mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    sik_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_q, last_d;   // 0 = thread 1, 1 = thread 2
    logic          sel_q, sel_d;
    logic          we_q, we_d;

    logic          ack1_q, ack1_d, ack2_q, ack2_d;
    logic [15:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;

    logic elig1, elig2, grant, gsel, capture;

    // The thread being acked still has req high, so it sits out this round.
    assign elig1   = bus.req1 && !(state_q == ACK && !sel_q);
    assign elig2   = bus.req2 && !(state_q == ACK &&  sel_q);
    assign grant   = (state_q == IDLE || state_q == ACK) && (elig1 || elig2);
    assign gsel    = (elig1 && elig2) ? ~last_q : elig2;
    assign capture = (state_q == WAIT) && (cnt_q == 2'd0) && !we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            ack1_q      <= 1'b0;
            ack2_q      <= 1'b0;
            rdata1_q    <= 16'h0000;
            rdata2_q    <= 16'h0000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            ack1_q      <= ack1_d;
            ack2_q      <= ack2_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        we_d    = we_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ACK:     state_d = grant ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if (grant) begin
            sel_d  = gsel;
            last_d = gsel;
            we_d   = gsel ? bus.we2 : bus.we1;
        end
    end

    // Outputs are registered off the next state so they line up with it.
    always_comb begin
        ack1_d      = (state_d == ACK) && !sel_d;
        ack2_d      = (state_d == ACK) &&  sel_d;
        busy_d      = (state_d != IDLE);
        mem_en_d    = (state_d == ISSUE);
        mem_we_d    = (state_d == ISSUE) && we_d;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        if (grant) begin
            mem_addr_d  = gsel ? bus.addr2  : bus.addr1;
            mem_wdata_d = gsel ? bus.wdata2 : bus.wdata1;
        end
        if (capture && !sel_q) rdata1_d = bus.mem_rdata;
        if (capture &&  sel_q) rdata2_d = bus.mem_rdata;
    end

    assign bus.ack1      = ack1_q;
    assign bus.ack2      = ack2_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.rdata2    = rdata2_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sik_mem_arbiter.sv
// Directed bench: a MEM_LAT=1 and a MEM_LAT=3 arbiter share stimulus; the idle one is held in reset.
module tb_sik_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, dsel;
    logic        req1, we1, req2, we2;
    logic [15:0] addr1, wdata1, addr2, wdata2;

    sik_mem_arbiter_if #(.AW(16)) ifa ();
    sik_mem_arbiter_if #(.AW(16)) ifb ();

    sik_mem_arbiter #(.MEM_LAT(1), .AW(16)) u_a (.clk(clk), .reset(rst_a), .bus(ifa));
    sik_mem_arbiter #(.MEM_LAT(3), .AW(16)) u_b (.clk(clk), .reset(rst_b), .bus(ifb));

    assign ifa.req1 = req1;  assign ifa.we1 = we1;  assign ifa.addr1 = addr1;  assign ifa.wdata1 = wdata1;
    assign ifa.req2 = req2;  assign ifa.we2 = we2;  assign ifa.addr2 = addr2;  assign ifa.wdata2 = wdata2;
    assign ifb.req1 = req1;  assign ifb.we1 = we1;  assign ifb.addr1 = addr1;  assign ifb.wdata1 = wdata1;
    assign ifb.req2 = req2;  assign ifb.we2 = we2;  assign ifb.addr2 = addr2;  assign ifb.wdata2 = wdata2;

    // Memory models: read data appears MEM_LAT cycles after the mem_en sample, 0xDEAD otherwise.
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] rd_a;
    logic [15:0] p_b [0:2];

    always @(posedge clk) begin
        if (rst_a) begin
            mem_a[1] <= 16'h1111;
            mem_a[2] <= 16'h2222;
            rd_a     <= 16'hDEAD;
        end else begin
            rd_a <= 16'hDEAD;
            if (ifa.mem_en) begin
                if (ifa.mem_we) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
                else            rd_a <= mem_a[ifa.mem_addr[7:0]];
            end
        end
    end
    assign ifa.mem_rdata = rd_a;

    always @(posedge clk) begin
        if (rst_b) mem_b[5] <= 16'h5A5A;
        else if (ifb.mem_en && ifb.mem_we) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
        p_b[0] <= (!rst_b && ifb.mem_en && !ifb.mem_we) ? mem_b[ifb.mem_addr[7:0]] : 16'hDEAD;
        p_b[1] <= p_b[0];
        p_b[2] <= p_b[1];
    end
    assign ifb.mem_rdata = p_b[2];

    logic        m_ack1, m_ack2, m_en, m_we, m_busy;
    logic [15:0] m_rd1, m_rd2, m_addr, m_wdata;
    assign m_ack1  = dsel ? ifb.ack1      : ifa.ack1;
    assign m_ack2  = dsel ? ifb.ack2      : ifa.ack2;
    assign m_en    = dsel ? ifb.mem_en    : ifa.mem_en;
    assign m_we    = dsel ? ifb.mem_we    : ifa.mem_we;
    assign m_busy  = dsel ? ifb.busy      : ifa.busy;
    assign m_rd1   = dsel ? ifb.rdata1    : ifa.rdata1;
    assign m_rd2   = dsel ? ifb.rdata2    : ifa.rdata2;
    assign m_addr  = dsel ? ifb.mem_addr  : ifa.mem_addr;
    assign m_wdata = dsel ? ifb.mem_wdata : ifa.mem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc, en_cnt, busy_cnt, both, n_ack1, n_ack2, nseq, ack1_cyc, ack2_cyc;
    logic        en_we;
    logic [15:0] en_addr, en_wdata, rd1, rd2;
    logic [7:0]  seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; en_cnt = 0; busy_cnt = 0; both = 0; n_ack1 = 0; n_ack2 = 0;
        nseq = 0; ack1_cyc = -1; ack2_cyc = -1; seq = 8'h00;
        en_we = 1'bx; en_addr = 16'hxxxx; en_wdata = 16'hxxxx; rd1 = 16'hxxxx; rd2 = 16'hxxxx;
    endtask

    // One clock, then sample the selected DUT 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_en) begin
            en_cnt++; en_we = m_we; en_addr = m_addr; en_wdata = m_wdata;
        end
        if (m_busy) busy_cnt++;
        if (m_ack1 && m_ack2) both++;
        if (m_ack1) begin
            n_ack1++; ack1_cyc = cyc; rd1 = m_rd1; seq = {seq[6:0], 1'b0}; nseq++;
        end
        if (m_ack2) begin
            n_ack2++; ack2_cyc = cyc; rd2 = m_rd2; seq = {seq[6:0], 1'b1}; nseq++;
        end
    endtask

    initial begin
        dsel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
        req2 = 1'b0; we2 = 1'b0; addr2 = 16'h0; wdata2 = 16'h0;
        clr();
        step(); step();
        chk("rst_ack1",  32'(m_ack1), 0);
        chk("rst_ack2",  32'(m_ack2), 0);
        chk("rst_rd1",   32'(m_rd1), 0);
        chk("rst_rd2",   32'(m_rd2), 0);
        chk("rst_mem",   32'({m_en, m_we, m_addr, m_wdata}), 0);
        chk("rst_busy",  32'(m_busy), 0);
        chk("rst_b_out", 32'({ifb.ack1, ifb.ack2, ifb.mem_en, ifb.mem_we, ifb.busy}), 0);

        // Idle after reset: nothing may move.
        rst_a = 1'b0;
        clr();
        repeat (5) step();
        chk("idle_en",   32'(en_cnt), 0);
        chk("idle_busy", 32'(busy_cnt), 0);
        chk("idle_ack",  32'(n_ack1 + n_ack2), 0);

        // Thread 1 store then load at 0x0010.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
        clr();
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_ack1) req1 = 1'b0;
        end
        chk("st_lat",   32'(ack1_cyc), 3);
        chk("st_nack",  32'(n_ack1), 1);
        chk("st_en",    32'(en_cnt), 1);
        chk("st_we",    32'(en_we), 1);
        chk("st_addr",  32'(en_addr), 32'h0010);
        chk("st_wdata", 32'(en_wdata), 32'hBEEF);
        chk("st_ack2",  32'(n_ack2), 0);

        req1 = 1'b1; we1 = 1'b0;
        clr();
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_ack1) req1 = 1'b0;
        end
        chk("ld_lat",  32'(ack1_cyc), 3);
        chk("ld_rd1",  32'(rd1), 32'hBEEF);
        chk("ld_en",   32'(en_cnt), 1);
        chk("ld_we",   32'(en_we), 0);
        chk("ld_ack2", 32'(n_ack2), 0);

        // Simultaneous requests straight after reset: thread 1 wins the tie.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0001;
        req2 = 1'b1; we2 = 1'b0; addr2 = 16'h0002;
        clr();
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack1) req1 = 1'b0;
            if (m_ack2) req2 = 1'b0;
        end
        chk("tie_ack1_cyc", 32'(ack1_cyc), 3);
        chk("tie_ack2_cyc", 32'(ack2_cyc), 6);
        chk("tie_rd1",      32'(rd1), 32'h1111);
        chk("tie_rd2",      32'(rd2), 32'h2222);
        chk("tie_rd1_hold", 32'(m_rd1), 32'h1111);
        chk("tie_both",     32'(both), 0);

        // Both threads hold req for six transactions: strict alternation.
        req1 = 1'b1; req2 = 1'b1;
        clr();
        for (int i = 0; i < 30; i++) begin
            step();
            if (nseq >= 6) begin
                req1 = 1'b0; req2 = 1'b0;
            end
        end
        chk("rr_seq",      32'(seq[5:0]), 32'h15);
        chk("rr_count",    32'(nseq), 6);
        chk("rr_both",     32'(both), 0);
        chk("rr_last_cyc", 32'(ack2_cyc), 18);

        // MEM_LAT=3 instance: thread 2 load.
        dsel = 1'b1; rst_a = 1'b1; rst_b = 1'b0;
        req2 = 1'b1; we2 = 1'b0; addr2 = 16'h0005;
        clr();
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack2) req2 = 1'b0;
        end
        chk("l3_lat",  32'(ack2_cyc), 5);
        chk("l3_busy", 32'(busy_cnt), 5);
        chk("l3_rd2",  32'(rd2), 32'h5A5A);
        chk("l3_en",   32'(en_cnt), 1);
        chk("l3_ack1", 32'(n_ack1), 0);

        // Reset during WAIT of a thread 1 store aborts it; held req is re-served.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0007; wdata1 = 16'h1234;
        clr();
        step();
        step();
        chk("ab_busy_wait", 32'(m_busy), 1);
        rst_b = 1'b1;
        step();
        chk("ab_busy_rst", 32'(m_busy), 0);
        chk("ab_en_rst",   32'(m_en), 0);
        chk("ab_no_ack",   32'(n_ack1), 0);
        rst_b = 1'b0;
        clr();
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack1) req1 = 1'b0;
        end
        chk("ab_relat", 32'(ack1_cyc), 5);
        chk("ab_nack",  32'(n_ack1), 1);
        chk("ab_we",    32'(en_we), 1);

        // Thread 2 reads back what thread 1 stored.
        req2 = 1'b1; we2 = 1'b0; addr2 = 16'h0007;
        clr();
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack2) req2 = 1'b0;
        end
        chk("xr_lat", 32'(ack2_cyc), 5);
        chk("xr_rd2", 32'(rd2), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
